// File: rtl/hpm_counter_bank_pkg.sv
// hpm_counter_bank_pkg: CSR map, inhibit bit positions and selector encodings for the counter bank
package hpm_counter_bank_pkg;
    localparam logic [11:0] CSR_MCYCLE           = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET         = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB00;
    localparam logic [11:0] CSR_MHPMEVENT_BASE   = 12'h320;
    localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;
    localparam int HPM_FIRST = 3;
    localparam int HPM_LAST  = 31;
    localparam int INH_CY = 0;
    localparam int INH_IR = 2;
    localparam logic [7:0] SEL_NONE    = 8'h00;
    localparam logic [7:0] SEL_RETIRED = 8'hFF;
    function automatic int of_pos(input int xlen);
        return xlen - 1;
    endfunction
endpackage

// File: rtl/hpm_counter_slice.sv
// hpm_counter_slice: one programmable counter with its event selector, inhibit bit and overflow flag
// Overflow flag only exists when HPM_OVERFLOW_IRQ_EN is defined.
module hpm_counter_slice
    import hpm_counter_bank_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CNT_W  = 64,
    parameter int NEVENT = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              cnt_we,
    input  logic              evt_we,
    input  logic              inh_we,
    input  logic              inh_wdata,
    input  logic [XLEN-1:0]   wdata,
    input  logic [NEVENT-1:0] event_i,
    input  logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        sel,
    output logic              inhibit,
    output logic              of
);
    logic             ev_hit;
    logic [CNT_W-1:0] inc;
    logic [CNT_W-1:0] sum;
    always_comb begin
        ev_hit = 1'b0;
        for (int e = 0; e < NEVENT; e++)
            if (sel == 8'(e + 1)) ev_hit = event_i[e];
    end
    assign inc = (sel == SEL_RETIRED) ? retired : CNT_W'(ev_hit);
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count   <= '0;
            sel     <= SEL_NONE;
            inhibit <= 1'b0;
        end else begin
            count   <= cnt_we ? wdata[CNT_W-1:0] : inhibit ? count : sum;
            sel     <= evt_we ? wdata[7:0] : sel;
            inhibit <= inh_we ? inh_wdata : inhibit;
        end
    end
`ifdef HPM_OVERFLOW_IRQ_EN
    logic carry;
    assign {carry, sum} = {1'b0, count} + {1'b0, inc};
    // a CSR write to the counter or event register overrides the wrap this cycle
    always_ff @(posedge clk_i) begin
        if (srst_i) of <= 1'b0;
        else of <= evt_we ? wdata[of_pos(XLEN)] : of | (carry & ~inhibit & ~cnt_we);
    end
`else
    assign sum = count + inc;
    assign of  = 1'b0;
`endif
endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: mcycle, minstret, NHPM programmable counters and mcountinhibit for the commit stage
// Define HPM_OVERFLOW_IRQ_EN to add sticky per-counter overflow flags and hpm_ovf_irq.
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int CNT_W    = 64,
    parameter int COMMIT_W = 2,
    parameter int NHPM     = 4,
    parameter int NEVENT   = 8
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                valid,
    input  logic                csren,
    input  logic [11:0]         csrindex,
    input  logic [XLEN-1:0]     csrdata,
    input  logic [COMMIT_W-1:0] commit_valid,
    input  logic [NEVENT-1:0]   event_i,
    input  logic [11:0]         rd_index,
    output logic [XLEN-1:0]     rd_data,
    output logic                rd_hit,
    output logic [CNT_W-1:0]    mcycle,
    output logic [CNT_W-1:0]    minstret,
    output logic [XLEN-1:0]     mcountinhibit,
    output logic                hpm_ovf_irq
);
    logic             we;
    logic             inh_cy;
    logic             inh_ir;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] hpm_cnt [NHPM];
    logic [7:0]       hpm_sel [NHPM];
    logic [NHPM-1:0]  hpm_inh;
    logic [NHPM-1:0]  hpm_of;
    assign we = valid & csren;
    always_comb begin
        retired = '0;
        for (int i = 0; i < COMMIT_W; i++) retired = retired + CNT_W'(commit_valid[i]);
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            mcycle   <= '0;
            minstret <= '0;
            inh_cy   <= 1'b0;
            inh_ir   <= 1'b0;
        end else begin
            mcycle   <= (we && csrindex == CSR_MCYCLE) ? csrdata[CNT_W-1:0] : inh_cy ? mcycle : mcycle + 1'b1;
            minstret <= (we && csrindex == CSR_MINSTRET) ? csrdata[CNT_W-1:0] : inh_ir ? minstret : minstret + retired;
            inh_cy   <= (we && csrindex == CSR_MCOUNTINHIBIT) ? csrdata[INH_CY] : inh_cy;
            inh_ir   <= (we && csrindex == CSR_MCOUNTINHIBIT) ? csrdata[INH_IR] : inh_ir;
        end
    end
    for (genvar k = 0; k < NHPM; k++) begin : g_hpm
        hpm_counter_slice #(.XLEN(XLEN), .CNT_W(CNT_W), .NEVENT(NEVENT)) u_slice (
            .clk_i     (clk_i),
            .srst_i    (srst_i),
            .cnt_we    (we && csrindex == CSR_MHPMCOUNTER_BASE + 12'(HPM_FIRST + k)),
            .evt_we    (we && csrindex == CSR_MHPMEVENT_BASE + 12'(HPM_FIRST + k)),
            .inh_we    (we && csrindex == CSR_MCOUNTINHIBIT),
            .inh_wdata (csrdata[HPM_FIRST + k]),
            .wdata     (csrdata),
            .event_i   (event_i),
            .retired   (retired),
            .count     (hpm_cnt[k]),
            .sel       (hpm_sel[k]),
            .inhibit   (hpm_inh[k]),
            .of        (hpm_of[k])
        );
    end
    always_comb begin
        mcountinhibit = '0;
        mcountinhibit[INH_CY] = inh_cy;
        mcountinhibit[INH_IR] = inh_ir;
        for (int k = 0; k < NHPM; k++) mcountinhibit[HPM_FIRST + k] = hpm_inh[k];
    end
    // unimplemented counters in the owned ranges hit but read as zero
    always_comb begin
        rd_data = '0;
        rd_hit  = rd_index == CSR_MCYCLE || rd_index == CSR_MINSTRET || rd_index == CSR_MCOUNTINHIBIT
               || (rd_index >= CSR_MHPMCOUNTER_BASE + 12'(HPM_FIRST) && rd_index <= CSR_MHPMCOUNTER_BASE + 12'(HPM_LAST))
               || (rd_index >= CSR_MHPMEVENT_BASE + 12'(HPM_FIRST) && rd_index <= CSR_MHPMEVENT_BASE + 12'(HPM_LAST));
        if (rd_index == CSR_MCYCLE) rd_data = XLEN'(mcycle);
        if (rd_index == CSR_MINSTRET) rd_data = XLEN'(minstret);
        if (rd_index == CSR_MCOUNTINHIBIT) rd_data = mcountinhibit;
        for (int k = 0; k < NHPM; k++) begin
            if (rd_index == CSR_MHPMCOUNTER_BASE + 12'(HPM_FIRST + k)) rd_data = XLEN'(hpm_cnt[k]);
            if (rd_index == CSR_MHPMEVENT_BASE + 12'(HPM_FIRST + k))
                rd_data = XLEN'(hpm_sel[k]) | (XLEN'(hpm_of[k]) << of_pos(XLEN));
        end
    end
    assign hpm_ovf_irq = |hpm_of;
endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: directed checks of counting, inhibit, event selection, write priority, overflow and read decode
module tb_hpm_counter_bank;
    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic        valid = 1'b0;
    logic        csren = 1'b0;
    logic [11:0] csrindex = '0;
    logic [63:0] csrdata = '0;
    logic [1:0]  commit_valid = '0;
    logic [7:0]  event_i = '0;
    logic [11:0] rd_index = '0;
    logic [63:0] rd_data;
    logic        rd_hit;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] mcountinhibit;
    logic        hpm_ovf_irq;
    int tests = 0;
    int fails = 0;
`ifdef HPM_OVERFLOW_IRQ_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    hpm_counter_bank dut (
        .clk_i(clk_i), .srst_i(srst_i), .valid(valid), .csren(csren), .csrindex(csrindex),
        .csrdata(csrdata), .commit_valid(commit_valid), .event_i(event_i), .rd_index(rd_index),
        .rd_data(rd_data), .rd_hit(rd_hit), .mcycle(mcycle), .minstret(minstret),
        .mcountinhibit(mcountinhibit), .hpm_ovf_irq(hpm_ovf_irq)
    );
    always #5 clk_i = ~clk_i;
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp, input logic exp_hit);
        rd_index = a;
        #1;
        chk({tag, "_data"}, rd_data, exp);
        chk({tag, "_hit"}, 64'(rd_hit), 64'(exp_hit));
    endtask
    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        valid = 1'b1;
        csren = 1'b1;
        csrindex = a;
        csrdata = d;
        step();
        valid = 1'b0;
        csren = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        step();
        step();
        chk("rst_mcycle", mcycle, 64'd0);
        chk("rst_minstret", minstret, 64'd0);
        chk("rst_inhibit", mcountinhibit, 64'd0);
        chk("rst_irq", 64'(hpm_ovf_irq), 64'd0);
        srst_i = 1'b0;
        repeat (10) step();
        chk("idle_mcycle", mcycle, 64'd10);
        chk("idle_minstret", minstret, 64'd0);
        rd("rd_mcycle", 12'hB00, 64'd10, 1'b1);
        rd("rd_hpm3_idle", 12'hB03, 64'd0, 1'b1);
        wr(12'h323, 64'hFF);
        commit_valid = 2'b11;
        repeat (5) step();
        commit_valid = 2'b01;
        repeat (3) step();
        commit_valid = 2'b00;
        chk("ret_minstret", minstret, 64'd13);
        rd("ret_hpm3", 12'hB03, 64'd13, 1'b1);
        rd("rd_evt3", 12'h323, 64'hFF, 1'b1);
        wr(12'hB00, 64'd1000);
        chk("wr_mcycle", mcycle, 64'd1000);
        wr(12'h320, 64'h7);
        chk("inh_old_incr", mcycle, 64'd1001);
        chk("inh_reg", mcountinhibit, 64'h5);
        commit_valid = 2'b11;
        repeat (3) step();
        commit_valid = 2'b00;
        chk("inh_mcycle", mcycle, 64'd1001);
        chk("inh_minstret", minstret, 64'd13);
        rd("inh_hpm3", 12'hB03, 64'd19, 1'b1);
        rd("rd_inhibit", 12'h320, 64'h5, 1'b1);
        wr(12'h320, 64'h0);
        chk("uninh_same", mcycle, 64'd1001);
        step();
        chk("uninh_next", mcycle, 64'd1002);
        wr(12'h324, 64'd2);
        for (int i = 0; i < 14; i++) begin
            event_i = (i % 2 == 0) ? 8'h02 : 8'h01;
            step();
        end
        event_i = 8'h00;
        rd("evt_hpm4", 12'hB04, 64'd7, 1'b1);
        rd("evt_hpm5", 12'hB05, 64'd0, 1'b1);
        event_i = 8'h02;
        wr(12'hB04, 64'd100);
        event_i = 8'h00;
        rd("wr_prio_hpm4", 12'hB04, 64'd100, 1'b1);
        wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        rd("ovf_preset", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        commit_valid = 2'b01;
        step();
        commit_valid = 2'b00;
        rd("ovf_wrap", 12'hB03, 64'd0, 1'b1);
        rd("ovf_flag", 12'h323, OVF ? 64'h8000_0000_0000_00FF : 64'hFF, 1'b1);
        chk("ovf_irq", 64'(hpm_ovf_irq), 64'(OVF));
        wr(12'h323, 64'hFF);
        chk("ovf_clear_irq", 64'(hpm_ovf_irq), 64'd0);
        rd("ovf_clear", 12'h323, 64'hFF, 1'b1);
        wr(12'h323, 64'h8000_0000_0000_00FF);
        chk("ovf_swset_irq", 64'(hpm_ovf_irq), 64'(OVF));
        rd("unimpl_cnt", 12'hB07, 64'd0, 1'b1);
        rd("unimpl_evt", 12'h327, 64'd0, 1'b1);
        rd("unowned", 12'h7C0, 64'd0, 1'b0);
        rd("unowned_b01", 12'hB01, 64'd0, 1'b0);
        srst_i = 1'b1;
        commit_valid = 2'b11;
        wr(12'hB00, 64'd55);
        srst_i = 1'b0;
        commit_valid = 2'b00;
        chk("mrst_mcycle", mcycle, 64'd0);
        chk("mrst_minstret", minstret, 64'd0);
        chk("mrst_irq", 64'(hpm_ovf_irq), 64'd0);
        rd("mrst_hpm4", 12'hB04, 64'd0, 1'b1);
        rd("mrst_evt4", 12'h324, 64'd0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
